usb_fs_rx_pkt_decode: RTL and testbench

Byte-level USB full-speed packet decoder that sits directly upstream of the OUT/IN protocol engines. It takes de-stuffed, NRZI-decoded bytes from the serial receiver front end and does four things: validates the PID, extracts token/SOF fields, checks CRC5 and CRC16, and streams payload bytes. Its output is the shared rx bus (rx_pkt_start/end/valid, rx_pid, rx_addr, rx_endp, rx_frame_num, rx_data_put, rx_data) consumed by all protocol engines.

---
 rtl/usb_fs_pkg.sv | 63 ++++++
 rtl/usb_fs_crc16_byte.sv | 20 ++
 rtl/usb_fs_rx_pkt_decode.sv | 156 +++++++++++++++
 tb/tb_usb_fs_rx_pkt_decode.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed receive definitions: PID codes, CRC constants, decoder states.
// Also holds the PID decode helpers and the bit-serial CRC5 byte update.
package usb_fs_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam logic [4:0]  CRC5_POLY      = 5'b00101;
   localparam logic [4:0]  CRC5_INIT      = 5'b11111;
   localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

   localparam int BYTE_CNT_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TOKEN = 3'd1,
      ST_DATA  = 3'd2,
      ST_HSHK  = 3'd3,
      ST_DROP  = 3'd4
   } rx_state_e;

   function automatic logic pid_is_valid(input logic [7:0] pid_byte);
      return pid_byte[7:4] == ~pid_byte[3:0];
   endfunction

   // Invalid or reserved (xx00) PIDs are swallowed without decoding.
   function automatic rx_state_e pid_next_state(input logic [7:0] pid_byte);
      rx_state_e nxt;
      nxt = ST_DROP;
      if (pid_is_valid(pid_byte)) begin
         case (pid_byte[1:0])
            2'b01:   nxt = ST_TOKEN;
            2'b11:   nxt = ST_DATA;
            2'b10:   nxt = ST_HSHK;
            default: nxt = ST_DROP;
         endcase
      end
      return nxt;
   endfunction

   function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
      logic [4:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (data[i] ^ c[4])
            c = {c[3:0], 1'b0} ^ CRC5_POLY;
         else
            c = {c[3:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/usb_fs_crc16_byte.sv
// Combinational CRC16 update for one byte, bits taken LSB first as they arrive on the wire.
module usb_fs_crc16_byte
   import usb_fs_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (data[i] ^ crc_out[15])
            crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
         else
            crc_out = {crc_out[14:0], 1'b0};
      end
   end

endmodule

// File: rtl/usb_fs_rx_pkt_decode.sv
// USB full-speed byte-level packet decoder: PID check, token/SOF fields, CRC5/CRC16, payload stream.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for an sop byte; stray bytes and eop ignored
//   ST_TOKEN | token/SOF: collecting the two field bytes, running CRC5
//   ST_DATA  | DATA0/1: streaming every byte out, running CRC16
//   ST_HSHK  | handshake: no bytes expected before eop
//   ST_DROP  | invalid/reserved PID: swallow bytes until eop
module usb_fs_rx_pkt_decode
   import usb_fs_pkg::*;
#(
   parameter int MAX_PKT_BYTES = 66
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_byte_valid,
   input  logic [7:0]  in_byte,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic        in_err,
   output logic        rx_pkt_start,
   output logic        rx_pkt_end,
   output logic        rx_pkt_valid,
   output logic [3:0]  rx_pid,
   output logic [6:0]  rx_addr,
   output logic [3:0]  rx_endp,
   output logic [10:0] rx_frame_num,
   output logic        rx_data_put,
   output logic [7:0]  rx_data
);

   localparam logic [BYTE_CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [BYTE_CNT_W-1:0] CNT_LIMIT = BYTE_CNT_W'(MAX_PKT_BYTES);
   localparam logic [BYTE_CNT_W-1:0] CNT_ONE   = BYTE_CNT_W'(1);
   localparam logic [BYTE_CNT_W-1:0] CNT_TWO   = BYTE_CNT_W'(2);

   rx_state_e             state;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic                  err_seen;
   logic [4:0]            crc5;
   logic [15:0]           crc16;
   logic [15:0]           crc16_next;
   logic                  sop_byte;
   logic                  len_ok;
   logic                  crc_ok;
   logic                  pkt_ok;

   assign sop_byte = in_byte_valid & in_sop;

   usb_fs_crc16_byte u_crc16 (
      .crc_in  (crc16),
      .data    (in_byte),
      .crc_out (crc16_next)
   );

   // An error strobe coinciding with eop still spoils the packet.
   always_comb begin
      len_ok = 1'b0;
      crc_ok = 1'b0;
      case (state)
         ST_TOKEN: begin
            len_ok = (byte_cnt == CNT_TWO);
            crc_ok = (crc5 == CRC5_RESIDUAL);
         end
         ST_HSHK: begin
            len_ok = (byte_cnt == '0);
            crc_ok = 1'b1;
         end
         ST_DATA: begin
            len_ok = (byte_cnt >= CNT_TWO) && (byte_cnt <= CNT_LIMIT);
            crc_ok = (crc16 == CRC16_RESIDUAL);
         end
         default: begin
            len_ok = 1'b0;
            crc_ok = 1'b0;
         end
      endcase
      pkt_ok = len_ok & crc_ok & ~(err_seen | in_err);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         byte_cnt     <= '0;
         err_seen     <= 1'b0;
         crc5         <= '0;
         crc16        <= '0;
         rx_pkt_start <= 1'b0;
         rx_pkt_end   <= 1'b0;
         rx_pkt_valid <= 1'b0;
         rx_pid       <= '0;
         rx_addr      <= '0;
         rx_endp      <= '0;
         rx_frame_num <= '0;
         rx_data_put  <= 1'b0;
         rx_data      <= '0;
      end else begin
         rx_pkt_start <= 1'b0;
         rx_pkt_end   <= 1'b0;
         rx_data_put  <= 1'b0;

         if (state == ST_IDLE) begin
            if (sop_byte) begin
               rx_pkt_start <= 1'b1;
               rx_pkt_valid <= 1'b0;
               rx_pid       <= in_byte[3:0];
               byte_cnt     <= '0;
               err_seen     <= 1'b0;
               crc5         <= CRC5_INIT;
               crc16        <= CRC16_INIT;
               state        <= pid_next_state(in_byte);
            end
         end else if (sop_byte) begin
            // A new sop mid-packet aborts; the intruding PID byte is discarded.
            rx_pkt_end   <= 1'b1;
            rx_pkt_valid <= 1'b0;
            state        <= ST_IDLE;
         end else if (in_eop) begin
            rx_pkt_end   <= 1'b1;
            rx_pkt_valid <= pkt_ok;
            state        <= ST_IDLE;
         end else begin
            if (in_err)
               err_seen <= 1'b1;
            if (in_byte_valid) begin
               if (byte_cnt != CNT_MAX)
                  byte_cnt <= byte_cnt + CNT_ONE;
               case (state)
                  ST_TOKEN: begin
                     crc5 <= crc5_byte(crc5, in_byte);
                     if (byte_cnt == '0) begin
                        rx_addr    <= in_byte[6:0];
                        rx_endp[0] <= in_byte[7];
                        if (rx_pid == PID_SOF)
                           rx_frame_num[7:0] <= in_byte;
                     end else if (byte_cnt == CNT_ONE) begin
                        rx_endp[3:1] <= in_byte[2:0];
                        if (rx_pid == PID_SOF)
                           rx_frame_num[10:8] <= in_byte[2:0];
                     end
                  end
                  ST_DATA: begin
                     crc16       <= crc16_next;
                     rx_data_put <= 1'b1;
                     rx_data     <= in_byte;
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_fs_rx_pkt_decode.sv
// Bench for usb_fs_rx_pkt_decode: packet-level reference model checked every cycle, plus literal checks.
module tb_usb_fs_rx_pkt_decode;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_byte_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic        in_err = 1'b0;
   logic        rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_data_put;
   logic [3:0]  rx_pid, rx_endp;
   logic [6:0]  rx_addr;
   logic [10:0] rx_frame_num;
   logic [7:0]  rx_data;

   usb_fs_rx_pkt_decode #(.MAX_PKT_BYTES(66)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_byte_valid(in_byte_valid),
      .in_byte      (in_byte),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .in_err       (in_err),
      .rx_pkt_start (rx_pkt_start),
      .rx_pkt_end   (rx_pkt_end),
      .rx_pkt_valid (rx_pkt_valid),
      .rx_pid       (rx_pid),
      .rx_addr      (rx_addr),
      .rx_endp      (rx_endp),
      .rx_frame_num (rx_frame_num),
      .rx_data_put  (rx_data_put),
      .rx_data      (rx_data)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic chk_en = 1'b0;

   function void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: packet bytes are collected whole and judged at eop.
   logic        m_start = 0, m_end = 0, m_valid = 0, m_put = 0;
   logic [7:0]  m_data = 0;
   logic [3:0]  m_pid = 0, m_endp = 0;
   logic [6:0]  m_addr = 0;
   logic [10:0] m_frame = 0;
   logic        m_in_pkt = 0, m_err = 0;
   logic [7:0]  pkt[$];
   logic [7:0]  tx[$];

   function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      logic fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         fb = b[i] ^ c[0];
         c = c >> 1;
         if (fb) c = c ^ 16'hA001;
      end
      return c;
   endfunction

   function automatic logic pid_ok(input logic [7:0] p);
      return p[7:4] == ~p[3:0];
   endfunction

   function logic judge();
      logic [7:0]  p, b1, b2;
      logic [4:0]  c5;
      logic [15:0] c;
      logic        bv, fb;
      int          n;
      p = pkt[0];
      n = int'(pkt.size()) - 1;
      if (!pid_ok(p) || m_err) return 1'b0;
      case (p[1:0])
         2'b01: begin
            if (n != 2) return 1'b0;
            b1 = pkt[1];
            b2 = pkt[2];
            c5 = 5'h1F;
            for (int i = 0; i < 11; i++) begin
               bv = (i < 8) ? b1[i] : b2[i-8];
               fb = bv ^ c5[0];
               c5 = c5 >> 1;
               if (fb) c5 = c5 ^ 5'h14;
            end
            return (~c5) == b2[7:3];
         end
         2'b10: return n == 0;
         2'b11: begin
            if (n < 2 || n > 66) return 1'b0;
            c = 16'hFFFF;
            for (int i = 1; i <= n - 2; i++) c = crc16_upd(c, pkt[i]);
            c = ~c;
            return (pkt[n-1] == c[7:0]) && (pkt[n] == c[15:8]);
         end
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_start = 0; m_end = 0; m_valid = 0; m_put = 0; m_data = 0;
         m_pid = 0; m_addr = 0; m_endp = 0; m_frame = 0;
         m_in_pkt = 0; m_err = 0;
         pkt.delete();
      end else begin
         m_start = 0; m_end = 0; m_put = 0;
         if (m_in_pkt && in_err) m_err = 1;
         if (in_byte_valid && in_sop) begin
            if (m_in_pkt) begin
               m_end = 1; m_valid = 0; m_in_pkt = 0;
            end else begin
               m_start = 1; m_valid = 0; m_pid = in_byte[3:0];
               pkt.delete(); pkt.push_back(in_byte);
               m_in_pkt = 1; m_err = 0;
            end
         end else if (in_eop && m_in_pkt) begin
            m_end = 1; m_valid = judge(); m_in_pkt = 0;
         end else if (in_byte_valid && m_in_pkt) begin
            pkt.push_back(in_byte);
            if (pid_ok(pkt[0]) && pkt[0][1:0] == 2'b11) begin
               m_put = 1; m_data = in_byte;
            end
            if (pid_ok(pkt[0]) && pkt[0][1:0] == 2'b01) begin
               if (pkt.size() == 2) begin
                  m_addr = in_byte[6:0]; m_endp[0] = in_byte[7];
                  if (m_pid == 4'b0101) m_frame[7:0] = in_byte;
               end else if (pkt.size() == 3) begin
                  m_endp[3:1] = in_byte[2:0];
                  if (m_pid == 4'b0101) m_frame[10:8] = in_byte[2:0];
               end
            end
         end
      end
   end

   int          obs_start = 0, obs_end = 0, obs_put = 0;
   logic        obs_valid = 0;
   logic [3:0]  obs_pid = 0, obs_endp = 0;
   logic [6:0]  obs_addr = 0;
   logic [10:0] obs_frame = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("start", 16'(rx_pkt_start), 16'(m_start));
         chk("end", 16'(rx_pkt_end), 16'(m_end));
         chk("valid", 16'(rx_pkt_valid), 16'(m_valid));
         chk("put", 16'(rx_data_put), 16'(m_put));
         if (m_put) chk("data", 16'(rx_data), 16'(m_data));
         chk("pid", 16'(rx_pid), 16'(m_pid));
         chk("addr", 16'(rx_addr), 16'(m_addr));
         chk("endp", 16'(rx_endp), 16'(m_endp));
         chk("frame", 16'(rx_frame_num), 16'(m_frame));
      end
      if (rx_pkt_start === 1'b1) obs_start++;
      if (rx_data_put === 1'b1) obs_put++;
      if (rx_pkt_end === 1'b1) begin
         obs_end++;
         obs_valid = rx_pkt_valid;
         obs_pid   = rx_pid;
         obs_addr  = rx_addr;
         obs_endp  = rx_endp;
         obs_frame = rx_frame_num;
      end
   end

   task automatic drive(input logic v, input logic [7:0] b, input logic s, input logic e, input logic r);
      @(posedge clk); #1;
      in_byte_valid = v; in_byte = b; in_sop = s; in_eop = e; in_err = r;
   endtask

   task automatic put_byte(input logic [7:0] b, input logic s);
      drive(1'b1, b, s, 1'b0, 1'b0);
   endtask

   task automatic put_idle(input int n);
      repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_obs();
      obs_start = 0; obs_end = 0; obs_put = 0; obs_valid = 0;
   endtask

   task automatic send_tx();
      clear_obs();
      foreach (tx[i]) put_byte(tx[i], i == 0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      put_idle(2);
   endtask

   task automatic make_data(input logic [7:0] pidb, input int len);
      logic [15:0] c;
      logic [7:0]  b;
      tx.delete();
      tx.push_back(pidb);
      c = 16'hFFFF;
      for (int i = 0; i < len; i++) begin
         b = 8'((i * 13) + 7);
         tx.push_back(b);
         c = crc16_upd(c, b);
      end
      c = ~c;
      tx.push_back(c[7:0]);
      tx.push_back(c[15:8]);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_valid", 16'(rx_pkt_valid), 16'h0);
      chk("rst_pid", 16'(rx_pid), 16'h0);
      chk("rst_frame", 16'(rx_frame_num), 16'h0);

      tx = '{8'h2D, 8'h00, 8'h10};
      send_tx();
      chk("setup_start", 16'(obs_start), 16'd1);
      chk("setup_pid", 16'(obs_pid), 16'hD);
      chk("setup_addr", 16'(obs_addr), 16'h0);
      chk("setup_endp", 16'(obs_endp), 16'h0);
      chk("setup_valid", 16'(obs_valid), 16'h1);
      chk("setup_puts", 16'(obs_put), 16'd0);

      tx = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
      send_tx();
      chk("getdesc_puts", 16'(obs_put), 16'd10);
      chk("getdesc_valid", 16'(obs_valid), 16'h1);
      tx[2] = 8'h07;
      send_tx();
      chk("getdesc_flip_valid", 16'(obs_valid), 16'h0);

      tx = '{8'hD2};
      send_tx();
      chk("ack_pid", 16'(obs_pid), 16'h2);
      chk("ack_valid", 16'(obs_valid), 16'h1);
      tx = '{8'hD2, 8'h00};
      send_tx();
      chk("ack_extra_valid", 16'(obs_valid), 16'h0);
      tx = '{8'hD3};
      send_tx();
      chk("badpid_start", 16'(obs_start), 16'd1);
      chk("badpid_valid", 16'(obs_valid), 16'h0);

      tx = '{8'h2D, 8'h00, 8'h11};
      send_tx();
      chk("tok_badcrc_valid", 16'(obs_valid), 16'h0);

      clear_obs();
      put_byte(8'hC3, 1'b1);
      put_byte(8'h80, 1'b0);
      put_byte(8'h06, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      foreach (tx[i]) if (i > 2) put_byte(tx[i], 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      put_idle(2);
      chk("err_valid", 16'(obs_valid), 16'h0);

      make_data(8'h4B, 65);
      send_tx();
      chk("long_puts", 16'(obs_put), 16'd67);
      chk("long_valid", 16'(obs_valid), 16'h0);
      make_data(8'h4B, 64);
      send_tx();
      chk("max_valid", 16'(obs_valid), 16'h1);
      tx = '{8'hC3, 8'h00, 8'h00};
      send_tx();
      chk("zlp_puts", 16'(obs_put), 16'd2);
      chk("zlp_valid", 16'(obs_valid), 16'h1);

      tx = '{8'hA5, 8'h23, 8'h01};
      send_tx();
      chk("sof_frame", 16'(obs_frame), 16'h123);
      chk("sof_addr", 16'(obs_addr), 16'h23);
      chk("sof_endp", 16'(obs_endp), 16'h2);

      clear_obs();
      put_byte(8'hC3, 1'b1);
      put_byte(8'h80, 1'b0);
      put_byte(8'h06, 1'b0);
      put_byte(8'hC3, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      put_idle(2);
      chk("abort_start", 16'(obs_start), 16'd1);
      chk("abort_end", 16'(obs_end), 16'd1);
      chk("abort_valid", 16'(obs_valid), 16'h0);

      clear_obs();
      put_byte(8'hE1, 1'b1);
      put_byte(8'h85, 1'b0);
      put_idle(1);
      chk("prereset_addr", 16'(rx_addr), 16'h5);
      reset = 1'b1;
      put_idle(1);
      reset = 1'b0;
      put_idle(2);
      chk("rst_mid_end", 16'(obs_end), 16'd0);
      chk("rst_mid_addr", 16'(rx_addr), 16'h0);
      chk("rst_mid_endp", 16'(rx_endp), 16'h0);
      chk("rst_mid_pid", 16'(rx_pid), 16'h0);
      chk("rst_mid_valid", 16'(rx_pkt_valid), 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
